// File: rtl/ad_ip_jesd204_tpl_adc_sync_capture.sv
// Arm/external-sync capture gate in front of a first-word-fall-through FIFO toward DMA; out_valid one cycle after first push.
// No upstream backpressure: a full, non-popping FIFO drops the beat and sets sticky overflow. Optional ARMED timeout: ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN.
module ad_ip_jesd204_tpl_adc_sync_capture #(
   parameter int NUM_CHANNELS      = 4,
   parameter int DATA_PATH_WIDTH   = 2,
   parameter int BITS_PER_SAMPLE   = 16,
   parameter int FIFO_DEPTH_LOG2   = 3,
   parameter int CAPTURE_LEN_WIDTH = 32,
   localparam int DW = NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [DW-1:0]                in_data,
   input  logic [NUM_CHANNELS-1:0]      adc_enable,
   input  logic                         adc_sync,
   input  logic                         adc_external_sync,
   input  logic                         ext_sync_edge_sel,
   input  logic [CAPTURE_LEN_WIDTH-1:0] capture_length,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DW-1:0]                out_data,
   output logic                         adc_sync_status,
   output logic                         capture_done,
   output logic                         overflow,
   input  logic                         overflow_clr
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
   ,
   input  logic [15:0]                  arm_timeout,
   output logic                         arm_timeout_err
`endif
);

   localparam int CW    = DATA_PATH_WIDTH*BITS_PER_SAMPLE;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] FULL_OCC = (FIFO_DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_t;

   state_t                       state_q, state_d;
   logic                         ext_d1_q, ext_d2_q;
   logic                         armed_entry_q, armed_entry_d;
   logic [CAPTURE_LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
   logic                         sync_status_q, sync_status_d;
   logic                         done_q, done_d;
   logic                         overflow_q, overflow_d;
   logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_LOG2:0]     occ_q, occ_d;
   logic [DW-1:0]                mem_q [DEPTH];
   logic [DW-1:0]                wr_data;
   logic                         edge_det, forwarding, push, pop, full, wr_en;
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
   logic [15:0]                  tmo_q, tmo_d;
   logic                         tmo_err_q, tmo_err_d, tmo_hit, tmo_set;
`endif

   always_comb begin
      edge_det   = ext_sync_edge_sel ? (~ext_d1_q & ext_d2_q) : (ext_d1_q & ~ext_d2_q);
      forwarding = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);
      out_valid  = (occ_q != '0);
      out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
      push       = in_valid & forwarding;
      pop        = out_valid & out_ready;
      full       = (occ_q == FULL_OCC);
      // A full FIFO still takes the beat when the head leaves in the same cycle.
      wr_en      = push & (~full | pop);
      wr_data    = in_data;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (!adc_enable[c]) wr_data[c*CW +: CW] = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      cnt_inc = cnt_q + 1'b1;
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
      tmo_set = 1'b0;
      tmo_hit = (arm_timeout != '0) && ((tmo_q + 16'd1) == arm_timeout);
`endif
      case (state_q)
         ST_IDLE: begin
            if (adc_sync) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (adc_sync) begin
               state_d = ST_IDLE;
            end else if (edge_det && !armed_entry_q) begin
               state_d = ST_CAPTURE;
               cnt_d   = '0;
               len_d   = capture_length;
            end
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = ST_IDLE;
               tmo_set = 1'b1;
            end
`endif
         end
         ST_CAPTURE: begin
            if (in_valid) cnt_d = cnt_inc;
            if (adc_sync) begin
               state_d = ST_IDLE;
            end else if (in_valid && (len_q != '0) && (cnt_inc == len_q)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (adc_sync) state_d = ST_ARMED;
         end
         default: state_d = ST_IDLE;
      endcase

      armed_entry_d = (state_d == ST_ARMED) && (state_q != ST_ARMED);
      sync_status_d = (state_d == ST_ARMED);
      done_d        = (state_d == ST_DONE);
      overflow_d    = (push & full & ~pop) | (overflow_q & ~overflow_clr);

      occ_d = occ_q;
      if (wr_en && !pop)      occ_d = occ_q + 1'b1;
      else if (!wr_en && pop) occ_d = occ_q - 1'b1;
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
      tmo_d     = (state_q == ST_ARMED) ? tmo_q + 16'd1 : '0;
      tmo_err_d = tmo_set | (tmo_err_q & ~overflow_clr);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ext_d1_q      <= 1'b0;
         ext_d2_q      <= 1'b0;
         armed_entry_q <= 1'b0;
         cnt_q         <= '0;
         len_q         <= '0;
         sync_status_q <= 1'b0;
         done_q        <= 1'b0;
         overflow_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
         tmo_q         <= '0;
         tmo_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         ext_d1_q      <= adc_external_sync;
         ext_d2_q      <= ext_d1_q;
         armed_entry_q <= armed_entry_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         sync_status_q <= sync_status_d;
         done_q        <= done_d;
         overflow_q    <= overflow_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         occ_q         <= occ_d;
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
         tmo_q         <= tmo_d;
         tmo_err_q     <= tmo_err_d;
`endif
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign adc_sync_status = sync_status_q;
   assign capture_done    = done_q;
   assign overflow        = overflow_q;
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
   assign arm_timeout_err = tmo_err_q;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_sync_capture.sv
// Randomized-data bench for the sync capture block; expected streams are built from the capture rules in queues.
module tb_ad_ip_jesd204_tpl_adc_sync_capture;
   localparam int NCH = 4;
   localparam int CW  = 2*16;
   localparam int DW  = NCH*CW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic [DW-1:0]  in_data = '0;
   logic [NCH-1:0] adc_enable = '1;
   logic           adc_sync = 1'b0;
   logic           adc_external_sync = 1'b0;
   logic           ext_sync_edge_sel = 1'b0;
   logic [31:0]    capture_length = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [DW-1:0]  out_data;
   logic           adc_sync_status;
   logic           capture_done;
   logic           overflow;
   logic           overflow_clr = 1'b0;
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
   logic [15:0]    arm_timeout = '0;
   logic           arm_timeout_err;
`endif

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   ad_ip_jesd204_tpl_adc_sync_capture dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .adc_enable(adc_enable),
      .adc_sync(adc_sync), .adc_external_sync(adc_external_sync), .ext_sync_edge_sel(ext_sync_edge_sel),
      .capture_length(capture_length), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .adc_sync_status(adc_sync_status), .capture_done(capture_done), .overflow(overflow),
      .overflow_clr(overflow_clr)
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
      , .arm_timeout(arm_timeout), .arm_timeout_err(arm_timeout_err)
`endif
   );

   // Everything the DMA side accepts, sampled mid-cycle.
   always @(negedge clk) if (!rst && out_valid && out_ready) got_q.push_back(out_data);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] rnd_beat();
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [DW-1:0] mask(input logic [DW-1:0] d, input logic [NCH-1:0] en);
      logic [DW-1:0] v;
      v = d;
      for (int c = 0; c < NCH; c++) if (!en[c]) v[c*CW +: CW] = '0;
      return v;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!out_valid) break;
         cycle();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_timeout: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset();
      logic [DW-1:0] d;
      cycle(); cycle();
      checks += 5;
      if (out_valid !== 1'b0)       begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (out_data !== '0)          begin failures++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      if (adc_sync_status !== 1'b0) begin failures++; $display("FAIL rst_status: got %b want 0", adc_sync_status); end
      if (capture_done !== 1'b0)    begin failures++; $display("FAIL rst_done: got %b want 0", capture_done); end
      if (overflow !== 1'b0)        begin failures++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      rst = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         d = rnd_beat();
         in_data = d;
         cycle();
         checks += 2;
         if (out_valid !== 1'b1 || out_data !== d) begin
            failures++; $display("FAIL idle_fwd%0d: got v=%b %h want v=1 %h", k, out_valid, out_data, d);
         end
         if (overflow !== 1'b0) begin failures++; $display("FAIL idle_ovf%0d: got %b want 0", k, overflow); end
      end
      drain();
   endtask

   task automatic test_capture_rising();
      logic [DW-1:0] d;
      logic es, ed;
      int arm_len;
      got_q.delete(); exp_q.delete();
      ext_sync_edge_sel = 1'b0;
      capture_length = 32'd5;
      adc_sync = 1'b1;
      adc_external_sync = 1'b1;   // edge lands in the first ARMED cycle and must be ignored
      cycle();
      adc_sync = 1'b0;
      in_valid = 1'b1;
      arm_len = $urandom_range(2, 5);
      for (int k = 0; k < arm_len + 2; k++) begin
         if (k >= arm_len) adc_external_sync = 1'b0;
         in_data = rnd_beat();
         cycle();
         checks++;
         if (adc_sync_status !== 1'b1) begin failures++; $display("FAIL armed_hold%0d: got %b want 1", k, adc_sync_status); end
      end
      for (int t = 0; t < 15; t++) begin
         adc_external_sync = 1'b1;
         d = rnd_beat();
         in_data = d;
         if (t >= 2 && t <= 6) exp_q.push_back(d);
         if (t == 3) capture_length = 32'd2;
         cycle();
         es = (t + 1 <= 1);
         ed = (t + 1 >= 7);
         checks += 2;
         if (adc_sync_status !== es) begin failures++; $display("FAIL cap_status_t%0d: got %b want %b", t, adc_sync_status, es); end
         if (capture_done !== ed)    begin failures++; $display("FAIL cap_done_t%0d: got %b want %b", t, capture_done, ed); end
      end
      drain();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL cap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL cap_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_falling_edge();
      logic [DW-1:0] d;
      logic es, ed;
      got_q.delete(); exp_q.delete();
      adc_external_sync = 1'b0;
      cycle(); cycle();
      ext_sync_edge_sel = 1'b1;
      capture_length = 32'd3;
      adc_sync = 1'b1;
      cycle();
      adc_sync = 1'b0;
      checks++;
      if (adc_sync_status !== 1'b1) begin failures++; $display("FAIL rearm_status: got %b want 1", adc_sync_status); end
      in_valid = 1'b1;
      adc_external_sync = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = rnd_beat();
         cycle();
         checks++;
         if (adc_sync_status !== 1'b1) begin failures++; $display("FAIL fall_rise_ignored%0d: got %b want 1", k, adc_sync_status); end
      end
      for (int t = 0; t < 9; t++) begin
         adc_external_sync = 1'b0;
         d = rnd_beat();
         in_data = d;
         if (t >= 2 && t <= 4) exp_q.push_back(d);
         cycle();
         es = (t + 1 <= 1);
         ed = (t + 1 >= 5);
         checks += 2;
         if (adc_sync_status !== es) begin failures++; $display("FAIL fall_status_t%0d: got %b want %b", t, adc_sync_status, es); end
         if (capture_done !== ed)    begin failures++; $display("FAIL fall_done_t%0d: got %b want %b", t, capture_done, ed); end
      end
      drain();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL fall_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] b [12];
      logic eo;
      got_q.delete(); exp_q.delete();
      ext_sync_edge_sel = 1'b0;
      capture_length = '0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      adc_sync = 1'b1;
      cycle();
      adc_sync = 1'b0;
      adc_external_sync = 1'b1;
      cycle(); cycle();
      checks++;
      if (adc_sync_status !== 1'b0) begin failures++; $display("FAIL ovf_enter_capture: got %b want 0", adc_sync_status); end
      for (int k = 1; k <= 10; k++) begin
         b[k] = rnd_beat();
         in_data = b[k];
         in_valid = 1'b1;
         overflow_clr = (k == 10);
         if (k <= 8) exp_q.push_back(b[k]);
         cycle();
         eo = (k >= 9);
         checks += 2;
         if (overflow !== eo) begin failures++; $display("FAIL ovf_flag_k%0d: got %b want %b", k, overflow, eo); end
         if (out_valid !== 1'b1 || out_data !== b[1]) begin
            failures++; $display("FAIL ovf_head_hold_k%0d: got v=%b %h want v=1 %h", k, out_valid, out_data, b[1]);
         end
      end
      in_valid = 1'b0;
      overflow_clr = 1'b1;
      cycle();
      overflow_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
      b[11] = rnd_beat();
      in_data = b[11];
      in_valid = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(b[11]);
      cycle();
      checks += 2;
      if (overflow !== 1'b0)     begin failures++; $display("FAIL ovf_full_pushpop: got %b want 0", overflow); end
      if (capture_done !== 1'b0) begin failures++; $display("FAIL continuous_done: got %b want 0", capture_done); end
      drain();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL ovf_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_enable_abort_reset();
      logic [DW-1:0] d;
      logic [NCH-1:0] en;
      got_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         en = (k < 2) ? 4'b0101 : NCH'($urandom);
         d = rnd_beat();
         adc_enable = en;
         in_data = d;
         exp_q.push_back(mask(d, en));
         cycle();
      end
      adc_enable = '1;
      drain();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL en_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL en_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
      adc_sync = 1'b1;
      cycle();
      checks += 2;
      if (adc_sync_status !== 1'b0) begin failures++; $display("FAIL abort_status: got %b want 0", adc_sync_status); end
      if (capture_done !== 1'b0)    begin failures++; $display("FAIL abort_done: got %b want 0", capture_done); end
      cycle();
      adc_sync = 1'b0;
      checks++;
      if (adc_sync_status !== 1'b1) begin failures++; $display("FAIL abort_then_arm: got %b want 1", adc_sync_status); end
      adc_external_sync = 1'b0;
      cycle();
      adc_external_sync = 1'b1;
      cycle(); cycle();
      checks++;
      if (adc_sync_status !== 1'b0) begin failures++; $display("FAIL rst_cap_enter: got %b want 0", adc_sync_status); end
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = rnd_beat();
         cycle();
      end
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
      if (out_data !== '0)    begin failures++; $display("FAIL async_rst_data: got %h want 0", out_data); end
      cycle();
      rst = 1'b0;
      in_valid = 1'b0;
      got_q.delete();
      cycle();
      checks += 3;
      if (out_valid !== 1'b0)       begin failures++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
      if (adc_sync_status !== 1'b0) begin failures++; $display("FAIL post_rst_status: got %b want 0", adc_sync_status); end
      if (overflow !== 1'b0)        begin failures++; $display("FAIL post_rst_ovf: got %b want 0", overflow); end
      d = rnd_beat();
      in_data = d;
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== d) begin
         failures++; $display("FAIL post_rst_idle_fwd: got v=%b %h want v=1 %h", out_valid, out_data, d);
      end
      drain();
   endtask

`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
   task automatic test_arm_timeout();
      adc_external_sync = 1'b0;
      in_valid = 1'b0;
      cycle(); cycle();
      arm_timeout = 16'd100;
      adc_sync = 1'b1;
      cycle();
      adc_sync = 1'b0;
      for (int i = 1; i < 100; i++) begin
         cycle();
         checks++;
         if (adc_sync_status !== 1'b1 || arm_timeout_err !== 1'b0) begin
            failures++; $display("FAIL tmo_wait%0d: got st=%b err=%b want st=1 err=0", i, adc_sync_status, arm_timeout_err);
         end
      end
      cycle();
      checks++;
      if (adc_sync_status !== 1'b0 || arm_timeout_err !== 1'b1) begin
         failures++; $display("FAIL tmo_expire: got st=%b err=%b want st=0 err=1", adc_sync_status, arm_timeout_err);
      end
      overflow_clr = 1'b1;
      cycle();
      overflow_clr = 1'b0;
      arm_timeout = '0;
      checks++;
      if (arm_timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear: got %b want 0", arm_timeout_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_capture_rising();
      test_falling_edge();
      test_overflow();
      test_enable_abort_reset();
`ifdef ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN
      test_arm_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ad_ip_jesd204_tpl_adc_sync_capture.md
Name: ad_ip_jesd204_tpl_adc_sync_capture

Overview:
Parametrised successor to the TPL ADC core's arm/external-sync logic. It sits between the deframer/channel formatting path and the DMA interface. It adds:
- an explicit arm/capture state machine with a selectable sync edge;
- a finite capture length;
- per-channel enables;
- a FIFO that absorbs DMA backpressure, with sticky overflow reporting.

Parameters:
NUM_CHANNELS, 4, number of converter channels
DATA_PATH_WIDTH, 2, samples per channel per beat
BITS_PER_SAMPLE, 16, formatted sample width
FIFO_DEPTH_LOG2, 3, FIFO depth = 2**FIFO_DEPTH_LOG2 beats (min 1)
CAPTURE_LEN_WIDTH, 32, width of capture_length
DW (derived), NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE, beat width

Ports:
clk  in  1  clock; one clock domain
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  formatted beat valid from channel path; no backpressure upstream
in_data  in  DW  formatted beat, channel i at [i*DATA_PATH_WIDTH*BITS_PER_SAMPLE +: DATA_PATH_WIDTH*BITS_PER_SAMPLE]
adc_enable  in  NUM_CHANNELS  per-channel enable
adc_sync  in  1  single-cycle arm/disarm request
adc_external_sync  in  1  external sync level, may be asynchronous
ext_sync_edge_sel  in  1  0 = rising edge, 1 = falling edge
capture_length  in  CAPTURE_LEN_WIDTH  beats per capture; 0 = continuous
out_valid  out  1  FIFO non-empty
out_ready  in  1  DMA accepts head beat
out_data  out  DW  FIFO head beat
adc_sync_status  out  1  1 while in ARMED
capture_done  out  1  1 while in DONE
overflow  out  1  sticky; beat dropped on full FIFO
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; FIFO empty; beat counter 0.
  - Sync flops ext_d1/ext_d2 = 0.
  - All outputs 0.
- Sync input path:
  - ext_d1 <= adc_external_sync and ext_d2 <= ext_d1, every cycle in every state.
  - edge = (ext_d1 & ~ext_d2) when sel = 0; (~ext_d1 & ext_d2) when sel = 1.
- State machine transitions:
  - IDLE: forwards every in_valid beat. adc_sync -> ARMED.
  - ARMED: forwards nothing. adc_sync -> IDLE. Otherwise edge -> CAPTURE, loading the counter with 0.
    - An edge occurring in the cycle the FSM enters ARMED is ignored.
  - CAPTURE: forwards every in_valid beat and counts it (count += 1).
    - capture_length != 0 and the count reaches capture_length on this beat -> DONE.
    - adc_sync -> IDLE (abort), and the abort takes priority over completion.
    - capture_length = 0: stays until adc_sync -> IDLE.
  - DONE: forwards nothing. adc_sync -> ARMED (re-arm).
- Capture latency:
  - Sync edge at pin in cycle N: edge visible N+1; CAPTURE from N+2.
  - The first captured beat is the first in_valid beat at or after N+2.
- Capture length:
  - capture_length is sampled on the edge into CAPTURE.
  - Later changes do not affect the capture in progress.
- FIFO:
  - Push = in_valid & forwarding state.
  - Write data has each disabled channel's slice forced to 0; enables are sampled on the push cycle.
  - First-word-fall-through. out_valid rises the cycle after the first push into an empty FIFO.
  - Pop = out_valid & out_ready. out_data is held stable while out_valid & ~out_ready.
  - Full with push and pop in the same cycle: push accepted, no overflow.
  - Full with push and no pop: beat dropped, overflow set. A dropped beat still counts toward capture_length.
  - Pointers wrap modulo depth. Occupancy has FIFO_DEPTH_LOG2+1 bits.
  - The FIFO drains normally after leaving CAPTURE/IDLE; state changes never flush it.
- Overflow register: set-and-clear in the same cycle -> set wins.
- Status outputs:
  - adc_sync_status and capture_done are registered state decodes.
  - Both are valid the cycle after the transition.
- Reset asserted mid-capture: immediately returns to IDLE, discards FIFO contents, deasserts out_valid.

Optional Feature:
Macro ADC_SYNC_CAPTURE_ARM_TIMEOUT_EN.
- Defined:
  - Adds input arm_timeout [15:0] and output arm_timeout_err (sticky, cleared by overflow_clr).
  - A cycle counter starts at 0 on entry to ARMED.
  - arm_timeout != 0, counter reaches arm_timeout with no edge -> IDLE and arm_timeout_err set.
  - An edge in the same cycle the timeout expires wins -> CAPTURE.
- Undefined: ports absent; ARMED waits indefinitely.

Test Plan:
- Reset with continuous in_valid, out_ready=1, all channels enabled -> IDLE forwarding; out_data equals in_data delayed one cycle; no overflow.
- adc_sync pulse, then rising external edge, capture_length=5, in_valid constant -> adc_sync_status high until edge; exactly 5 beats emitted, starting with the beat 2 cycles after the pin edge; capture_done=1; no further pushes.
- ext_sync_edge_sel=1, rising edge while ARMED -> stays ARMED; subsequent falling edge -> CAPTURE.
- FIFO_DEPTH_LOG2=3, out_ready=0, 10 beats in continuous mode -> 8 stored, overflow=1; overflow_clr asserted in the same cycle as a drop -> overflow stays 1; release out_ready -> 8 beats in order.
- adc_enable=4'b0101 -> channel 1 and 3 slices read 0; adc_sync in CAPTURE -> IDLE; async rst mid-capture -> out_valid=0 in the same cycle.
- ARM_TIMEOUT_EN, arm_timeout=100, no edge -> IDLE at cycle 100 of ARMED, arm_timeout_err=1.
